pc_fetch_sequencer: RTL and testbench

Program-counter and fetch sequencer for the 8-bit MIPS datapath.
- Holds the 8-bit PC and supplies PC+1 to the address mux's sequential input.
- Drives the mux's 2-bit select from the redirect requests and loads the mux output back into the PC.
- Runs the request/acknowledge handshake with instruction memory.
- Sits in the address computation block between the control unit and instruction memory.

---
 rtl/pc_fetch_sequencer.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: program counter and instruction fetch sequencer
// for the 8-bit MIPS datapath address computation block.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   jr_req, jump_req,     redirect requests that pick the address mux
//   branch_taken          input (priority jr > jump > branch)
//   exec_done, stall      advance handshake from the control unit
//   addr_in               address mux output, loaded into pc
//   sel                   address mux select (combinational)
//   pc, pc_plus1          current pc and pc+1 (mod 256, combinational)
//   imem_req, imem_addr   instruction memory request / address
//   imem_ack, imem_rdata  memory acknowledge and fetched word
//   instr, instr_valid    latched instruction and its update pulse
//   fetch_err             pulse when a fetch times out and is retried
module pc_fetch_sequencer #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter int         INSTR_W      = 32,
    parameter int         TIMEOUT      = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               jr_req,
    input  logic               jump_req,
    input  logic               branch_taken,
    input  logic               exec_done,
    input  logic               stall,
    input  logic [7:0]         addr_in,
    output logic [1:0]         sel,
    output logic [7:0]         pc,
    output logic [7:0]         pc_plus1,
    output logic               imem_req,
    output logic [7:0]         imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               fetch_err
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        RETRY,
        EXEC
    } state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t               state_q;
    state_t               state_d;
    logic [7:0]           wait_q;
    logic [7:0]           wait_d;
    logic [7:0]           pc_q;
    logic [7:0]           pc_d;
    logic [INSTR_W-1:0]   instr_q;
    logic [INSTR_W-1:0]   instr_d;
    logic                 req_q;
    logic                 req_d;
    logic                 vld_q;
    logic                 vld_d;
    logic                 err_q;
    logic                 err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            wait_q  <= 8'd0;
            pc_q    <= RESET_VECTOR;
            instr_q <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        sel     = 2'b00;

        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    vld_d   = 1'b1;
                    wait_d  = 8'd0;
                    state_d = EXEC;
                end else if (wait_q == TO) begin
                    err_d   = 1'b1;
                    wait_d  = 8'd0;
                    state_d = RETRY;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end

            RETRY: begin
                state_d = FETCH;
            end

            EXEC: begin
                priority case (1'b1)
                    jr_req:       sel = 2'b11;
                    jump_req:     sel = 2'b10;
                    branch_taken: sel = 2'b01;
                    default:      sel = 2'b00;
                endcase
                if (exec_done && !stall) begin
                    pc_d    = addr_in;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase

        // Request is a flop of the next state so it never glitches.
        req_d = (state_d == FETCH);
    end

    assign pc          = pc_q;
    assign pc_plus1    = pc_q + 8'd1;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed and randomized checks of the
// pc/fetch sequencer against a transaction-level expectation model.
module tb_pc_fetch_sequencer;

    localparam int T = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        jr_req;
    logic        jump_req;
    logic        branch_taken;
    logic        exec_done;
    logic        stall;
    logic [7:0]  addr_in;
    logic [1:0]  sel;
    logic [7:0]  pc;
    logic [7:0]  pc_plus1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fetch_err;

    logic        loop_en;
    logic [7:0]  addr_drv;

    int vectors = 0;
    int miscompares = 0;

    assign addr_in = loop_en ? pc_plus1 : addr_drv;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(
        .RESET_VECTOR(8'h00),
        .INSTR_W(32),
        .TIMEOUT(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .jr_req(jr_req),
        .jump_req(jump_req),
        .branch_taken(branch_taken),
        .exec_done(exec_done),
        .stall(stall),
        .addr_in(addr_in),
        .sel(sel),
        .pc(pc),
        .pc_plus1(pc_plus1),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_valid(instr_valid),
        .fetch_err(fetch_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, 64'(pc), 64'h00);
        chk({tag, "_pc1"}, 64'(pc_plus1), 64'h01);
        chk({tag, "_sel"}, 64'(sel), 64'h0);
        chk({tag, "_req"}, 64'(imem_req), 64'h0);
        chk({tag, "_addr"}, 64'(imem_addr), 64'h00);
        chk({tag, "_instr"}, 64'(instr), 64'h0);
        chk({tag, "_vld"}, 64'(instr_valid), 64'h0);
        chk({tag, "_err"}, 64'(fetch_err), 64'h0);
    endtask

    function automatic logic [1:0] exp_sel(input logic j, input logic m,
                                           input logic b);
        if (j) return 2'b11;
        if (m) return 2'b10;
        if (b) return 2'b01;
        return 2'b00;
    endfunction

    logic [7:0]  exp_pc;
    logic [7:0]  exp_p1;
    logic [7:0]  a;
    logic [31:0] w;
    int          run;
    int          lat;
    int          waited;
    bit          acked;
    bit          accept;

    initial begin
        rst = 1'b1;
        jr_req = 0; jump_req = 0; branch_taken = 0;
        exec_done = 0; stall = 0;
        imem_ack = 0; imem_rdata = '0;
        loop_en = 0; addr_drv = 8'h00;

        #1;
        chk_reset("rst0");
        imem_ack = 1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        chk_reset("rst1");
        tick();
        chk_reset("rst2");

        // release, first request one cycle after the first edge
        rst = 1'b0;
        exec_done = 1;
        loop_en = 1;
        chk("boot_req", 64'(imem_req), 64'h0);
        tick();
        chk("boot_req1", 64'(imem_req), 64'h1);
        chk("boot_addr", 64'(imem_addr), 64'h00);

        // sequential run through the wrap
        exp_pc = 8'h00;
        for (int k = 0; k <= 256; k++) begin
            exp_p1 = exp_pc + 8'd1;
            chk("seq_req", 64'(imem_req), 64'h1);
            chk("seq_addr", 64'(imem_addr), 64'(exp_pc));
            chk("seq_pc1", 64'(pc_plus1), 64'(exp_p1));
            w = $urandom;
            imem_rdata = w;
            tick();
            chk("seq_vld", 64'(instr_valid), 64'h1);
            chk("seq_instr", 64'(instr), 64'(w));
            chk("seq_req0", 64'(imem_req), 64'h0);
            tick();
            exp_pc = exp_p1;
        end

        // move to pc=10 and hold in EXEC
        exec_done = 0;
        loop_en = 0;
        addr_drv = 8'h10;
        tick();
        exec_done = 1;
        tick();
        exec_done = 0;
        chk("to10_addr", 64'(imem_addr), 64'h10);
        tick();
        chk("to10_vld", 64'(instr_valid), 64'h1);

        jr_req = 1; jump_req = 1; branch_taken = 1;
        #1 chk("pri_jr", 64'(sel), 64'h3);
        jr_req = 0;
        #1 chk("pri_jump", 64'(sel), 64'h2);
        jump_req = 0;
        #1 chk("pri_br", 64'(sel), 64'h1);
        branch_taken = 0;
        #1 chk("pri_seq", 64'(sel), 64'h0);
        branch_taken = 1;
        addr_drv = 8'h40;
        exec_done = 1;
        tick();
        chk("redir_addr", 64'(imem_addr), 64'h40);
        chk("redir_req", 64'(imem_req), 64'h1);
        chk("fetch_sel", 64'(sel), 64'h0);
        exec_done = 0;
        branch_taken = 0;
        tick();

        // stall holds the pc while exec_done is high
        exec_done = 1;
        stall = 1;
        addr_drv = 8'h55;
        for (int i = 0; i < 5; i++) begin
            jump_req = i[0];
            #1 chk("stall_sel", 64'(sel), i[0] ? 64'h2 : 64'h0);
            tick();
            chk("stall_pc", 64'(pc), 64'h40);
            chk("stall_req", 64'(imem_req), 64'h0);
        end
        stall = 0;
        jump_req = 0;
        tick();
        chk("unstall_pc", 64'(pc), 64'h55);
        chk("unstall_req", 64'(imem_req), 64'h1);
        exec_done = 0;
        imem_ack = 0;

        // timeout and retry at the same address
        for (int i = 1; i <= T + 1; i++) begin
            chk("to_req", 64'(imem_req), 64'h1);
            chk("to_noerr", 64'(fetch_err), 64'h0);
            tick();
        end
        chk("to_err", 64'(fetch_err), 64'h1);
        chk("to_req0", 64'(imem_req), 64'h0);
        tick();
        chk("to_err0", 64'(fetch_err), 64'h0);
        chk("retry_req", 64'(imem_req), 64'h1);
        chk("retry_addr", 64'(imem_addr), 64'h55);
        w = 32'hA5A5_0F0F;
        imem_rdata = w;
        imem_ack = 1;
        tick();
        chk("retry_vld", 64'(instr_valid), 64'h1);
        chk("retry_instr", 64'(instr), 64'(w));
        chk("retry_err", 64'(fetch_err), 64'h0);
        imem_ack = 0;

        // asynchronous reset mid-fetch at pc=25
        addr_drv = 8'h25;
        exec_done = 1;
        tick();
        exec_done = 0;
        chk("mid_req", 64'(imem_req), 64'h1);
        chk("mid_addr", 64'(imem_addr), 64'h25);
        #2;
        rst = 1'b1;
        imem_ack = 1;
        #1;
        chk_reset("arst");
        tick();
        chk("arst_vld1", 64'(instr_valid), 64'h0);
        tick();
        chk("arst_vld2", 64'(instr_valid), 64'h0);
        rst = 1'b0;
        imem_ack = 0;
        tick();
        chk("rel_req", 64'(imem_req), 64'h1);
        chk("rel_addr", 64'(imem_addr), 64'h00);
        chk("rel_vld", 64'(instr_valid), 64'h0);
        tick();
        chk("rel_vld2", 64'(instr_valid), 64'h0);
        chk("rel_req2", 64'(imem_req), 64'h1);

        // randomized instruction stream
        exp_pc = 8'h00;
        run = 1;
        for (int n = 0; n < 150; n++) begin
            lat = $urandom_range(0, 6);
            waited = 0;
            acked = 0;
            while (!acked) begin
                jr_req = 1'($urandom);
                jump_req = 1'($urandom);
                branch_taken = 1'($urandom);
                exec_done = 1'($urandom);
                #1;
                chk("r_fsel", 64'(sel), 64'h0);
                chk("r_freq", 64'(imem_req), 64'h1);
                chk("r_faddr", 64'(imem_addr), 64'(exp_pc));
                if (waited == lat) begin
                    w = $urandom;
                    imem_rdata = w;
                    imem_ack = 1;
                    tick();
                    imem_ack = 0;
                    chk("r_vld", 64'(instr_valid), 64'h1);
                    chk("r_instr", 64'(instr), 64'(w));
                    chk("r_err0", 64'(fetch_err), 64'h0);
                    acked = 1;
                    run = 0;
                end else begin
                    imem_ack = 0;
                    imem_rdata = $urandom;
                    tick();
                    waited++;
                    run++;
                    if (run == T + 1) begin
                        chk("r_err", 64'(fetch_err), 64'h1);
                        chk("r_rreq", 64'(imem_req), 64'h0);
                        run = 0;
                        imem_ack = 1'($urandom);
                        tick();
                        imem_ack = 0;
                        chk("r_err1", 64'(fetch_err), 64'h0);
                    end else begin
                        chk("r_noerr", 64'(fetch_err), 64'h0);
                    end
                end
            end
            accept = 0;
            for (int c = 0; !accept; c++) begin
                jr_req = 1'($urandom);
                jump_req = 1'($urandom);
                branch_taken = 1'($urandom);
                imem_ack = 1'($urandom);
                a = 8'($urandom);
                addr_drv = a;
                stall = ($urandom_range(0, 3) == 0) && (c < 20);
                exec_done = ($urandom_range(0, 2) != 0) || (c >= 20);
                #1;
                chk("r_sel", 64'(sel),
                    64'(exp_sel(jr_req, jump_req, branch_taken)));
                accept = exec_done && !stall;
                tick();
                imem_ack = 0;
                if (accept) exp_pc = a;
                chk("r_pc", 64'(pc), 64'(exp_pc));
                chk("r_ereq", 64'(imem_req), accept ? 64'h1 : 64'h0);
                chk("r_evld", 64'(instr_valid), 64'h0);
            end
            stall = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
